// File: rtl/e203_tcm_sram_arb_pkg.sv
// Shared types and defaults for the TCM SRAM arbiter: low-power state encoding,
// default RAM geometry and the idle-counter helper.
package e203_tcm_sram_arb_pkg;

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_SLEEP  = 2'd1,
      ST_WAKE   = 2'd2
   } lp_state_e;

   localparam int TCM_AW  = 14;
   localparam int TCM_DW  = 32;
   localparam int IDLE_CW = 8;

   // Saturating increment so a long idle stretch never wraps back to zero.
   function automatic logic [IDLE_CW-1:0] sat_inc(input logic [IDLE_CW-1:0] v);
      return (v == {IDLE_CW{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/e203_tcm_rsp_buf.sv
// Single-entry response tracker: remembers who owns the in-flight access and
// holds RAM read data while the owner back-pressures the response.
module e203_tcm_rsp_buf
   import e203_tcm_sram_arb_pkg::*;
#(
   parameter int DW = TCM_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          accept,
   input  logic          accept_id,
   input  logic          accept_read,
   input  logic [DW-1:0] ram_dout,
   input  logic [1:0]    rsp_ready,
   output logic [1:0]    rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          pending,
   output logic          ctl_free
);

   logic          pending_reg;
   logic          owner_reg;
   logic          read_reg;
   logic          hold_vld_reg;
   logic [DW-1:0] hold_data_reg;
   logic          rsp_hs;

   assign rsp_hs   = pending_reg && rsp_ready[owner_reg];
   assign ctl_free = !pending_reg || rsp_hs;
   assign pending  = pending_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
         assign rsp_valid[gi] = pending_reg && (owner_reg == 1'(gi));
      end
   endgenerate

   // RAM output is only valid for one cycle after the access; later cycles use the hold copy.
   assign rsp_rdata = !read_reg    ? '0 :
                      hold_vld_reg ? hold_data_reg : ram_dout;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_reg   <= 1'b0;
         owner_reg     <= 1'b0;
         read_reg      <= 1'b0;
         hold_vld_reg  <= 1'b0;
         hold_data_reg <= '0;
      end else if (accept) begin
         pending_reg  <= 1'b1;
         owner_reg    <= accept_id;
         read_reg     <= accept_read;
         hold_vld_reg <= 1'b0;
      end else if (rsp_hs) begin
         pending_reg  <= 1'b0;
         hold_vld_reg <= 1'b0;
      end else if (pending_reg && !hold_vld_reg) begin
         hold_vld_reg  <= 1'b1;
         hold_data_reg <= ram_dout;
      end
   end

endmodule

// File: rtl/e203_tcm_sram_arb.sv
// Round-robin arbiter sharing one single-port TCM SRAM between two ICB requesters,
// with one access in flight and an idle-driven light-sleep controller.
module e203_tcm_sram_arb
   import e203_tcm_sram_arb_pkg::*;
#(
   parameter int AW      = TCM_AW,
   parameter int DW      = TCM_DW,
   parameter int MW      = DW / 8,
   parameter int LS_IDLE = 16
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          m0_icb_cmd_valid,
   output logic          m0_icb_cmd_ready,
   input  logic          m0_icb_cmd_read,
   input  logic [AW-1:0] m0_icb_cmd_addr,
   input  logic [DW-1:0] m0_icb_cmd_wdata,
   input  logic [MW-1:0] m0_icb_cmd_wmask,
   output logic          m0_icb_rsp_valid,
   input  logic          m0_icb_rsp_ready,
   output logic [DW-1:0] m0_icb_rsp_rdata,

   input  logic          m1_icb_cmd_valid,
   output logic          m1_icb_cmd_ready,
   input  logic          m1_icb_cmd_read,
   input  logic [AW-1:0] m1_icb_cmd_addr,
   input  logic [DW-1:0] m1_icb_cmd_wdata,
   input  logic [MW-1:0] m1_icb_cmd_wmask,
   output logic          m1_icb_rsp_valid,
   input  logic          m1_icb_rsp_ready,
   output logic [DW-1:0] m1_icb_rsp_rdata,

   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [MW-1:0] ram_wem,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          ram_ls,
   output logic          ram_ds,
   output logic          ram_sd,

   input  logic          lp_en,
   output logic          busy
);

   localparam logic [IDLE_CW-1:0] LS_THRESH = IDLE_CW'(LS_IDLE - 1);

   lp_state_e            state_reg;
   logic [IDLE_CW-1:0]   idle_cnt_reg;
   logic                 rr_reg;

   logic [1:0]           cmd_valid;
   logic [1:0]           rsp_valid;
   logic                 win;
   logic                 grant;
   logic                 sel_read;
   logic                 pending;
   logic                 ctl_free;
   logic                 idle;
   logic [DW-1:0]        rsp_rdata;

   assign cmd_valid = {m1_icb_cmd_valid, m0_icb_cmd_valid};

   assign win   = (&cmd_valid) ? rr_reg : cmd_valid[1];
   assign grant = (state_reg == ST_ACTIVE) && ctl_free && (|cmd_valid);
   assign idle  = !(|cmd_valid) && !pending;

   assign m0_icb_cmd_ready = grant && !win;
   assign m1_icb_cmd_ready = grant && win;

   assign sel_read = win ? m1_icb_cmd_read : m0_icb_cmd_read;
   assign ram_cs   = grant;
   assign ram_we   = grant && !sel_read;
   assign ram_addr = win ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
   assign ram_din  = win ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
   assign ram_wem  = ram_we ? (win ? m1_icb_cmd_wmask : m0_icb_cmd_wmask) : '0;

   assign ram_ls = (state_reg == ST_SLEEP);
   assign ram_ds = 1'b0;
   assign ram_sd = 1'b0;
   assign busy   = pending || (state_reg != ST_ACTIVE);

   assign m0_icb_rsp_valid = rsp_valid[0];
   assign m1_icb_rsp_valid = rsp_valid[1];
   assign m0_icb_rsp_rdata = rsp_rdata;
   assign m1_icb_rsp_rdata = rsp_rdata;

   e203_tcm_rsp_buf #(.DW(DW)) u_rsp_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .accept      (grant),
      .accept_id   (win),
      .accept_read (sel_read),
      .ram_dout    (ram_dout),
      .rsp_ready   ({m1_icb_rsp_ready, m0_icb_rsp_ready}),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .pending     (pending),
      .ctl_free    (ctl_free)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_ACTIVE;
         idle_cnt_reg <= '0;
         rr_reg       <= 1'b0;
      end else begin
         if (grant && (&cmd_valid)) begin
            rr_reg <= !win;
         end
         case (state_reg)
            ST_ACTIVE: begin
               // Sleep on the edge where the idle run reaches LS_IDLE cycles.
               if (idle) begin
                  if (lp_en && (idle_cnt_reg >= LS_THRESH)) begin
                     state_reg    <= ST_SLEEP;
                     idle_cnt_reg <= '0;
                  end else begin
                     idle_cnt_reg <= sat_inc(idle_cnt_reg);
                  end
               end else begin
                  idle_cnt_reg <= '0;
               end
            end
            ST_SLEEP: begin
               if ((|cmd_valid) || !lp_en) begin
                  state_reg <= ST_WAKE;
               end
            end
            ST_WAKE: begin
               state_reg    <= ST_ACTIVE;
               idle_cnt_reg <= '0;
            end
            default: begin
               state_reg    <= ST_ACTIVE;
               idle_cnt_reg <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_e203_tcm_sram_arb.sv
// Randomised bench for e203_tcm_sram_arb: a behavioural RAM plus a cycle-level
// reference model of arbitration, response sequencing and light sleep.
module tb_e203_tcm_sram_arb;

   localparam int AW      = 14;
   localparam int DW      = 32;
   localparam int MW      = 4;
   localparam int LS_IDLE = 4;
   localparam int MEM_N   = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
   logic [AW-1:0] m0_icb_cmd_addr;
   logic [DW-1:0] m0_icb_cmd_wdata;
   logic [MW-1:0] m0_icb_cmd_wmask;
   logic          m0_icb_rsp_valid, m0_icb_rsp_ready;
   logic [DW-1:0] m0_icb_rsp_rdata;
   logic          m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
   logic [AW-1:0] m1_icb_cmd_addr;
   logic [DW-1:0] m1_icb_cmd_wdata;
   logic [MW-1:0] m1_icb_cmd_wmask;
   logic          m1_icb_rsp_valid, m1_icb_rsp_ready;
   logic [DW-1:0] m1_icb_rsp_rdata;
   logic          ram_cs, ram_we, ram_ls, ram_ds, ram_sd;
   logic [AW-1:0] ram_addr;
   logic [MW-1:0] ram_wem;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;
   logic          lp_en;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   e203_tcm_sram_arb #(.AW(AW), .DW(DW), .MW(MW), .LS_IDLE(LS_IDLE)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
      .m0_icb_cmd_read(m0_icb_cmd_read), .m0_icb_cmd_addr(m0_icb_cmd_addr),
      .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
      .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
      .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
      .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
      .m1_icb_cmd_read(m1_icb_cmd_read), .m1_icb_cmd_addr(m1_icb_cmd_addr),
      .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
      .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
      .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_ls(ram_ls), .ram_ds(ram_ds),
      .ram_sd(ram_sd), .lp_en(lp_en), .busy(busy)
   );

   function automatic logic [DW-1:0] seed_word(input int i);
      return 32'h9E3779B9 * (i + 1);
   endfunction

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural SRAM, aliased on the low address bits; output is garbage unless just read.
   logic [DW-1:0] mem [MEM_N];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_N; i++) mem[i] <= seed_word(i);
      end else if (ram_cs && ram_we) begin
         for (int b = 0; b < MW; b++)
            if (ram_wem[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_din[8*b +: 8];
      end
      if (ram_cs && !ram_we) ram_dout <= mem[ram_addr[5:0]];
      else                   ram_dout <= $urandom;
   end

   // Reference model: expected outputs from the rules, evaluated once inputs settle.
   logic [DW-1:0] ref_mem [MEM_N];
   int            m_mode;      // 0 awake, 1 asleep, 2 waking
   int            m_idle;
   bit            m_rr, m_pend, m_owner;
   logic [DW-1:0] m_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < MEM_N; i++) ref_mem[i] = seed_word(i);
         m_mode = 0; m_idle = 0; m_rr = 0; m_pend = 0; m_owner = 0; m_data = '0;
      end else begin
         bit v0, v1, any, both, rdy_own, free, win, gnt, rd, hs, idle_c;
         logic [AW-1:0] a;
         logic [DW-1:0] wd;
         logic [MW-1:0] wm;
         v0   = m0_icb_cmd_valid;
         v1   = m1_icb_cmd_valid;
         any  = v0 || v1;
         both = v0 && v1;
         rdy_own = m_owner ? m1_icb_rsp_ready : m0_icb_rsp_ready;
         free = !m_pend || rdy_own;
         win  = both ? m_rr : v1;
         gnt  = (m_mode == 0) && free && any;
         rd   = win ? m1_icb_cmd_read  : m0_icb_cmd_read;
         a    = win ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
         wd   = win ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
         wm   = win ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

         check_val("ctrl",
            {55'd0, m0_icb_cmd_ready, m1_icb_cmd_ready, ram_cs, ram_ls, busy,
             m0_icb_rsp_valid, m1_icb_rsp_valid, ram_ds, ram_sd},
            {55'd0, gnt && !win, gnt && win, gnt, m_mode == 1, m_pend || m_mode != 0,
             m_pend && !m_owner, m_pend && m_owner, 1'b0, 1'b0});
         if (gnt)
            check_val("ramcmd", {ram_we, ram_wem, ram_addr, ram_din},
                      {!rd, rd ? 4'h0 : wm, a, wd});
         if (m_pend)
            check_val("rdata", m_owner ? m1_icb_rsp_rdata : m0_icb_rsp_rdata, m_data);

         hs     = m_pend && rdy_own;
         idle_c = !any && !m_pend;
         if (hs) $display("txn m%0d rsp data %08h", m_owner, m_data);

         if (m_mode == 0) begin
            if (idle_c) begin
               m_idle++;
               if (lp_en && m_idle >= LS_IDLE) begin m_mode = 1; m_idle = 0; end
            end else m_idle = 0;
         end else if (m_mode == 1) begin
            if (any || !lp_en) m_mode = 2;
         end else begin
            m_mode = 0; m_idle = 0;
         end

         if (gnt) begin
            if (both) m_rr = !win;
            m_pend  = 1;
            m_owner = win;
            if (rd) m_data = ref_mem[a[5:0]];
            else begin
               m_data = '0;
               for (int b = 0; b < MW; b++)
                  if (wm[b]) ref_mem[a[5:0]][8*b +: 8] = wd[8*b +: 8];
            end
         end else if (hs) m_pend = 0;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drive(input int port, input bit v, input bit rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
      if (port == 0) begin
         m0_icb_cmd_valid = v; m0_icb_cmd_read = rd; m0_icb_cmd_addr = a;
         m0_icb_cmd_wdata = d; m0_icb_cmd_wmask = m;
      end else begin
         m1_icb_cmd_valid = v; m1_icb_cmd_read = rd; m1_icb_cmd_addr = a;
         m1_icb_cmd_wdata = d; m1_icb_cmd_wmask = m;
      end
   endtask

   task automatic quiet();
      drive(0, 0, 1, '0, '0, '0);
      drive(1, 0, 1, '0, '0, '0);
   endtask

   initial begin
      rst_n = 1'b0; lp_en = 1'b0;
      m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
      quiet();
      tick(3);
      rst_n = 1'b1;
      check_val("rst_outs", {m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid,
                             m1_icb_rsp_valid, ram_cs, ram_ls, busy}, 7'd0);

      // Write then read back on m0.
      drive(0, 1, 0, 14'h10, 32'hDEADBEEF, 4'hF); tick();
      drive(0, 1, 1, 14'h10, '0, '0);             tick();
      quiet();
      check_val("m0_rd", {m0_icb_rsp_valid, m1_icb_rsp_valid, m0_icb_rsp_rdata},
                {1'b1, 1'b0, 32'hDEADBEEF});
      tick(2);

      // Contention: alternate grants with one access per cycle.
      drive(0, 1, 1, 14'h3, '0, '0);
      drive(1, 1, 1, 14'h4, '0, '0);
      tick(4);
      quiet(); tick(2);

      // Byte write over all-ones.
      drive(0, 1, 0, 14'h20, 32'hFFFFFFFF, 4'hF);     tick();
      drive(0, 1, 0, 14'h20, 32'h11223344, 4'b0100);  tick();
      drive(0, 1, 1, 14'h20, '0, '0);                 tick();
      quiet();
      check_val("bytewr", m0_icb_rsp_rdata, 32'hFF22FFFF);
      tick(2);

      // Backpressure on m1 while m0 keeps requesting.
      m1_icb_rsp_ready = 1'b0;
      drive(1, 1, 1, 14'h10, '0, '0); tick();
      drive(1, 0, 1, '0, '0, '0);
      drive(0, 1, 1, 14'h5, '0, '0);  tick(3);
      m1_icb_rsp_ready = 1'b1;        tick();
      quiet(); tick(2);

      // Sleep after LS_IDLE idle cycles, then wake on an m0 request.
      lp_en = 1'b1; tick(8);
      drive(0, 1, 1, 14'h10, '0, '0); tick(4);
      quiet(); lp_en = 1'b0; tick(2);

      // Reset while m1's response is stalled.
      m1_icb_rsp_ready = 1'b0;
      drive(1, 1, 1, 14'h7, '0, '0); tick();
      quiet(); tick(2);
      rst_n = 1'b0; tick();
      rst_n = 1'b1; m1_icb_rsp_ready = 1'b1;
      check_val("rst_stall", {m0_icb_rsp_valid, m1_icb_rsp_valid, busy, ram_ls}, 4'd0);
      drive(0, 1, 1, 14'h1, '0, '0);
      drive(1, 1, 1, 14'h2, '0, '0);
      #1 check_val("rst_rr", {m0_icb_cmd_ready, m1_icb_cmd_ready}, 2'b10);
      tick(3);
      quiet(); tick();

      // Randomised traffic in segments of differing intensity.
      for (int seg = 0; seg < 40; seg++) begin
         int pv, pr;
         pv = (seg % 4 == 0) ? 3 : (seg % 4 == 1) ? 50 : 90;
         pr = (seg % 3 == 0) ? 40 : 90;
         for (int c = 0; c < 50; c++) begin
            if ($urandom_range(0, 99) < 3) lp_en = ~lp_en;
            for (int p = 0; p < 2; p++)
               drive(p, $urandom_range(0, 99) < pv, $urandom_range(0, 1) == 1,
                     14'($urandom_range(0, 63)) | 14'($urandom_range(0, 255) << 6),
                     $urandom, 4'($urandom_range(0, 15)));
            m0_icb_rsp_ready = $urandom_range(0, 99) < pr;
            m1_icb_rsp_ready = $urandom_range(0, 99) < pr;
            tick();
         end
      end
      quiet(); m0_icb_rsp_ready = 1'b1; m1_icb_rsp_ready = 1'b1;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
